mem_arbiter: RTL and testbench

Arbitrates the single off-chip SRAM between the IF stage (instruction fetch) and the MEM stage (load/store). It sequences each SRAM access through a fixed multi-cycle strobe pattern and acknowledges the owning requester. While a requester waits, the block raises that requester's stall line, which the hazard logic folds into its pipeline freeze. Data and address are 16-bit word quantities, matching the CPU datapath.

---
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one asynchronous SRAM between the IF and MEM pipeline stages.
// Each access runs IDLE -> ACCESS (WAIT_CYCLES strobe cycles) -> DONE (ack).
module mem_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req_i,
  input  logic [15:0] if_addr_i,
  output logic [15:0] if_data_o,
  output logic        if_ack_o,
  output logic        stall_if_o,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [15:0] mem_addr_i,
  input  logic [15:0] mem_wdata_i,
  output logic [15:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        stall_mem_o,
  output logic [15:0] sram_addr_o,
  output logic [15:0] sram_wdata_o,
  input  logic [15:0] sram_rdata_i,
  output logic        sram_data_oe_o,
  output logic        sram_ce_n_o,
  output logic        sram_oe_n_o,
  output logic        sram_we_n_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_mem_q, owner_mem_d;
  logic        write_q, write_d;
  logic        last_mem_q, last_mem_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] if_data_q, if_data_d;
  logic [15:0] mem_rdata_q, mem_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        data_oe_q, data_oe_d;
  logic        busy_q, busy_d;
  logic        mem_req_s;
  logic        grant_mem_s;

  assign mem_req_s   = mem_read_i | mem_write_i;
  // MEM normally wins, but yields to a waiting IF right after a MEM grant.
  assign grant_mem_s = mem_req_s & ~(last_mem_q & if_req_i);

  // Next-state, request latching and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_mem_d = owner_mem_q;
    write_d     = write_q;
    last_mem_d  = last_mem_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      IDLE: begin
        if (if_req_i | mem_req_s) begin
          state_d     = ACCESS;
          cnt_d       = 4'(WAIT_CYCLES - 1);
          owner_mem_d = grant_mem_s;
          last_mem_d  = grant_mem_s;
          write_d     = grant_mem_s & mem_write_i;
          addr_d      = grant_mem_s ? mem_addr_i : if_addr_i;
          if (grant_mem_s & mem_write_i) begin
            wdata_d = mem_wdata_i;
          end else begin
            wdata_d = wdata_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!write_q && owner_mem_q) begin
            mem_rdata_d = sram_rdata_i;
          end else if (!write_q) begin
            if_data_d = sram_rdata_i;
          end else begin
            mem_rdata_d = mem_rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Data bus stays driven through DONE so the SRAM sees hold time after WE rises.
    ce_n_d    = (state_d != ACCESS);
    oe_n_d    = !((state_d == ACCESS) && !write_d);
    we_n_d    = !((state_d == ACCESS) && write_d);
    data_oe_d = (state_d != IDLE) && write_d;
    if_ack_d  = (state_d == DONE) && !owner_mem_d;
    mem_ack_d = (state_d == DONE) && owner_mem_d;
    busy_d    = (state_d != IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      owner_mem_q <= 1'b0;
      write_q     <= 1'b0;
      last_mem_q  <= 1'b0;
      addr_q      <= 16'd0;
      wdata_q     <= 16'd0;
      if_data_q   <= 16'd0;
      mem_rdata_q <= 16'd0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      data_oe_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_mem_q <= owner_mem_d;
      write_q     <= write_d;
      last_mem_q  <= last_mem_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      data_oe_q   <= data_oe_d;
      busy_q      <= busy_d;
    end
  end

  assign if_data_o      = if_data_q;
  assign if_ack_o       = if_ack_q;
  assign mem_rdata_o    = mem_rdata_q;
  assign mem_ack_o      = mem_ack_q;
  assign sram_addr_o    = addr_q;
  assign sram_wdata_o   = wdata_q;
  assign sram_data_oe_o = data_oe_q;
  assign sram_ce_n_o    = ce_n_q;
  assign sram_oe_n_o    = oe_n_q;
  assign sram_we_n_o    = we_n_q;
  assign busy_o         = busy_q;
  assign stall_if_o     = if_req_i & ~if_ack_q;
  assign stall_mem_o    = mem_req_s & ~mem_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic checked every
// cycle against a schedule model (an access granted at cycle t acks at t+W+1).
module tb_mem_arbiter;
  localparam int W = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        if_req, mem_read, mem_write;
  logic [15:0] if_addr, mem_addr, mem_wdata, sram_rdata;
  logic [15:0] if_data, mem_rdata, sram_addr, sram_wdata;
  logic        if_ack, mem_ack, stall_if, stall_mem, data_oe, ce_n, oe_n, we_n, busy;

  // second instance with WAIT_CYCLES=1, MEM port only
  logic        w1_rd, w1_wr, w1_zero;
  logic [15:0] w1_addr, w1_wdata, w1_zero16;
  logic [15:0] w1_if_data, w1_mem_rdata, w1_sram_addr, w1_sram_wdata;
  logic        w1_if_ack, w1_mem_ack, w1_stall_if, w1_stall_mem, w1_doe, w1_ce_n, w1_oe_n, w1_we_n, w1_busy;

  mem_arbiter #(.WAIT_CYCLES(W)) u_dut (
    .CLK(CLK), .RST(RST),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_ack_o(if_ack), .stall_if_o(stall_if),
    .mem_read_i(mem_read), .mem_write_i(mem_write), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(mem_rdata), .mem_ack_o(mem_ack), .stall_mem_o(stall_mem),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
    .sram_data_oe_o(data_oe), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n), .busy_o(busy)
  );

  mem_arbiter #(.WAIT_CYCLES(1)) u_w1 (
    .CLK(CLK), .RST(RST),
    .if_req_i(w1_zero), .if_addr_i(w1_zero16), .if_data_o(w1_if_data), .if_ack_o(w1_if_ack), .stall_if_o(w1_stall_if),
    .mem_read_i(w1_rd), .mem_write_i(w1_wr), .mem_addr_i(w1_addr), .mem_wdata_i(w1_wdata),
    .mem_rdata_o(w1_mem_rdata), .mem_ack_o(w1_mem_ack), .stall_mem_o(w1_stall_mem),
    .sram_addr_o(w1_sram_addr), .sram_wdata_o(w1_sram_wdata), .sram_rdata_i(sram_rdata),
    .sram_data_oe_o(w1_doe), .sram_ce_n_o(w1_ce_n), .sram_oe_n_o(w1_oe_n), .sram_we_n_o(w1_we_n), .busy_o(w1_busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model state
  bit          m_active, m_mem, m_write, m_last_mem;
  int          m_t;
  logic [15:0] m_addr, m_wdata, e_if, e_mem;
  bit          saw_if_ack, saw_mem_ack;

  // snapshots of the last checked cycle
  logic        s_ce_n, s_oe_n, s_we_n, s_doe, s_if_ack, s_mem_ack, s_stall_if, s_stall_mem, s_busy;
  logic [15:0] s_if_data, s_mem_rdata, s_addr, s_wdata;
  logic        sw_we_n, sw_oe_n, sw_doe, sw_ack, sw_stall;
  logic [15:0] sw_wdata;

  task automatic check1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, got, exp);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0; m_mem = 1'b0; m_write = 1'b0; m_last_mem = 1'b0; m_t = 0;
    m_addr = 16'd0; m_wdata = 16'd0; e_if = 16'd0; e_mem = 16'd0;
  endtask

  // Check one cycle at the falling edge, advance the model, return just after the next rising edge.
  task automatic tick();
    int   k;
    bit   act, done;
    logic x_if_ack, x_mem_ack;
    @(negedge CLK);
    k         = cyc - m_t;
    act       = m_active && (k >= 1) && (k <= W);
    done      = m_active && (k == W + 1);
    x_if_ack  = done && !m_mem;
    x_mem_ack = done && m_mem;
    check1("ce_n", ce_n, !act);
    check1("oe_n", oe_n, !(act && !m_write));
    check1("we_n", we_n, !(act && m_write));
    check1("data_oe", data_oe, (act || done) && m_write);
    check1("if_ack", if_ack, x_if_ack);
    check1("mem_ack", mem_ack, x_mem_ack);
    check1("busy", busy, act || done);
    check1("stall_if", stall_if, if_req && !x_if_ack);
    check1("stall_mem", stall_mem, (mem_read || mem_write) && !x_mem_ack);
    check16("sram_addr", sram_addr, m_addr);
    check16("if_data", if_data, e_if);
    check16("mem_rdata", mem_rdata, e_mem);
    if ((act || done) && m_write) check16("sram_wdata", sram_wdata, m_wdata);
    s_ce_n = ce_n; s_oe_n = oe_n; s_we_n = we_n; s_doe = data_oe; s_if_ack = if_ack;
    s_mem_ack = mem_ack; s_stall_if = stall_if; s_stall_mem = stall_mem; s_busy = busy;
    s_if_data = if_data; s_mem_rdata = mem_rdata; s_addr = sram_addr; s_wdata = sram_wdata;
    sw_we_n = w1_we_n; sw_oe_n = w1_oe_n; sw_doe = w1_doe; sw_ack = w1_mem_ack;
    sw_stall = w1_stall_mem; sw_wdata = w1_sram_wdata;
    saw_if_ack  = x_if_ack;
    saw_mem_ack = x_mem_ack;
    if (RST) begin
      model_reset();
    end else begin
      if (act && k == W && !m_write) begin
        if (m_mem) e_mem = sram_rdata;
        else e_if = sram_rdata;
      end
      if (done) begin
        m_active = 1'b0;
      end else if (!m_active && (if_req || mem_read || mem_write)) begin
        m_mem      = (mem_read || mem_write) && !(m_last_mem && if_req);
        m_last_mem = m_mem;
        m_write    = m_mem && mem_write;
        m_addr     = m_mem ? mem_addr : if_addr;
        if (m_write) m_wdata = mem_wdata;
        m_active   = 1'b1;
        m_t        = cyc;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  bit owners[$];

  initial begin
    RST = 1'b1;
    if_req = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    if_addr = 16'd0; mem_addr = 16'd0; mem_wdata = 16'd0; sram_rdata = 16'd0;
    w1_rd = 1'b0; w1_wr = 1'b0; w1_zero = 1'b0; w1_zero16 = 16'd0; w1_addr = 16'd0; w1_wdata = 16'd0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;

    // reset values
    tick();
    check1("rst_busy", s_busy, 1'b0);
    check1("rst_ce_n", s_ce_n, 1'b1);
    check1("rst_we_n", s_we_n, 1'b1);
    check1("rst_doe", s_doe, 1'b0);
    check16("rst_addr", s_addr, 16'h0000);
    check16("rst_wdata", s_wdata, 16'h0000);
    check16("rst_if_data", s_if_data, 16'h0000);

    // fetch, W=2
    sram_rdata = 16'hA5A5; if_req = 1'b1; if_addr = 16'h0040;
    tick(); check1("fetch_stall_c0", s_stall_if, 1'b1); check1("fetch_ce_c0", s_ce_n, 1'b1);
    tick(); check1("fetch_ce_c1", s_ce_n, 1'b0); check1("fetch_oe_c1", s_oe_n, 1'b0);
    tick(); check1("fetch_ce_c2", s_ce_n, 1'b0); check1("fetch_stall_c2", s_stall_if, 1'b1);
    tick(); check1("fetch_ack_c3", s_if_ack, 1'b1); check16("fetch_data_c3", s_if_data, 16'hA5A5);
    check1("fetch_stall_c3", s_stall_if, 1'b0); check16("fetch_addr", s_addr, 16'h0040);
    if_req = 1'b0;
    tick(); check1("fetch_ack_c4", s_if_ack, 1'b0);

    // store
    mem_write = 1'b1; mem_addr = 16'h8000; mem_wdata = 16'h1234;
    tick(); check1("store_we_c0", s_we_n, 1'b1);
    tick(); check1("store_we_c1", s_we_n, 1'b0); check1("store_doe_c1", s_doe, 1'b1); check1("store_oe_c1", s_oe_n, 1'b1);
    tick(); check1("store_we_c2", s_we_n, 1'b0); check16("store_wdata", s_wdata, 16'h1234);
    tick(); check1("store_ack_c3", s_mem_ack, 1'b1); check1("store_doe_c3", s_doe, 1'b1); check1("store_we_c3", s_we_n, 1'b1);
    mem_write = 1'b0;
    tick(); check1("store_doe_c4", s_doe, 1'b0);

    // simultaneous requests from a fresh last-grant state
    RST = 1'b1; tick(); RST = 1'b0;
    if_req = 1'b1; if_addr = 16'h0100; mem_read = 1'b1; mem_addr = 16'h0200; sram_rdata = 16'h5A5A;
    tick(); check1("sim_stall_if_c0", s_stall_if, 1'b1);
    tick(); tick();
    tick(); check1("sim_mem_ack_c3", s_mem_ack, 1'b1); check16("sim_mem_rdata", s_mem_rdata, 16'h5A5A);
    check1("sim_stall_if_c3", s_stall_if, 1'b1);
    mem_read = 1'b0;
    tick(); check1("sim_stall_if_c4", s_stall_if, 1'b1);
    tick(); tick(); check1("sim_stall_if_c6", s_stall_if, 1'b1);
    tick(); check1("sim_if_ack_c7", s_if_ack, 1'b1); check16("sim_if_data", s_if_data, 16'h5A5A);
    if_req = 1'b0;
    tick();

    // anti-starvation: both held continuously
    if_req = 1'b1; mem_read = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (s_if_ack) owners.push_back(1'b0);
      if (s_mem_ack) owners.push_back(1'b1);
    end
    if_req = 1'b0; mem_read = 1'b0;
    checks++;
    if (owners.size() != 6) begin
      errors++;
      $display("FAIL starve_count: got %0d acks expected 6", owners.size());
    end
    if (owners.size() > 0) check1("starve_first_mem", owners[0], 1'b1);
    for (int i = 1; i < owners.size(); i++) check1("starve_alternate", owners[i], !owners[i-1]);
    tick(); tick();

    // reset mid-access, request held through it
    if_req = 1'b1; if_addr = 16'h0123;
    tick(); tick();
    RST = 1'b1;
    tick(); check1("rstmid_busy_c2", s_busy, 1'b1);
    RST = 1'b0;
    tick(); check1("rstmid_busy_c3", s_busy, 1'b0); check1("rstmid_ce_c3", s_ce_n, 1'b1);
    check1("rstmid_ack_c3", s_if_ack, 1'b0); check16("rstmid_addr_c3", s_addr, 16'h0000);
    tick(); tick(); check1("rstmid_ack_c5", s_if_ack, 1'b0);
    tick(); check1("rstmid_ack_c6", s_if_ack, 1'b1);
    if_req = 1'b0;
    tick();

    // WAIT_CYCLES=1 instance: read+write together is a write
    w1_rd = 1'b1; w1_wr = 1'b1; w1_addr = 16'h0F0F; w1_wdata = 16'hBEEF;
    tick(); check1("w1_we_c0", sw_we_n, 1'b1); check1("w1_stall_c0", sw_stall, 1'b1);
    tick(); check1("w1_we_c1", sw_we_n, 1'b0); check1("w1_oe_c1", sw_oe_n, 1'b1);
    check1("w1_doe_c1", sw_doe, 1'b1); check1("w1_ack_c1", sw_ack, 1'b0); check16("w1_wdata", sw_wdata, 16'hBEEF);
    tick(); check1("w1_ack_c2", sw_ack, 1'b1); check1("w1_stall_c2", sw_stall, 1'b0); check1("w1_we_c2", sw_we_n, 1'b1);
    w1_rd = 1'b0; w1_wr = 1'b0;
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (RST) RST = 1'b0;
      else if ($urandom_range(0, 79) == 0) RST = 1'b1;
      if (if_req) begin
        if (saw_if_ack) if_req = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = 16'($urandom);
      end
      if (mem_read || mem_write) begin
        if (saw_mem_ack) begin mem_read = 1'b0; mem_write = 1'b0; end
      end else if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 2))
          0: begin mem_read = 1'b1; mem_write = 1'b0; end
          1: begin mem_read = 1'b0; mem_write = 1'b1; end
          default: begin mem_read = 1'b1; mem_write = 1'b1; end
        endcase
        mem_addr = 16'($urandom); mem_wdata = 16'($urandom);
      end
      // address/data wiggles while an access is in flight must not leak into it
      if (m_active && $urandom_range(0, 1) == 0) begin
        if_addr = 16'($urandom); mem_addr = 16'($urandom); mem_wdata = 16'($urandom);
      end
      sram_rdata = 16'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
